// File: rtl/amiga_reset_ctl.sv
// Keyboard / power-on reset controller: stretches POR and turns a long KCLK low
// (Ctrl-Amiga-Amiga) into a stretched system reset on the _RST/_HLT nets.
module amiga_reset_ctl #(
  parameter int KCLK_HOLD_CYCLES = 3579545,
  parameter int RESET_MIN_CYCLES = 1431818,
  parameter int CNT_W            = 23
) (
  input  logic       CLK,
  input  logic       _RES,
  input  logic       KCLK,
  output logic       _RST_O,
  output logic       _HLT_O,
  output logic       RESET_ACTIVE,
  output logic [1:0] CAUSE
);

  typedef enum logic [2:0] {
    ST_POR,
    ST_IDLE,
    ST_ARM,
    ST_RESET,
    ST_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(KCLK_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(RESET_MIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       CAUSE_POR = 2'b01;
  localparam logic [1:0]       CAUSE_KBD = 2'b10;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       cause_reg, cause_next;
  logic             sync1_reg, ks_reg;
  logic             assert_reg, assert_next;

  always_ff @(posedge CLK or negedge _RES) begin
    if (!_RES) begin
      sync1_reg  <= 1'b1;
      ks_reg     <= 1'b1;
      state_reg  <= ST_POR;
      cnt_reg    <= '0;
      cause_reg  <= CAUSE_POR;
      assert_reg <= 1'b1;
    end else begin
      sync1_reg  <= KCLK;
      ks_reg     <= sync1_reg;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      cause_reg  <= cause_next;
      assert_reg <= assert_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cause_next = cause_reg;
    case (state_reg)
      ST_POR: begin
        if (cnt_reg == MIN_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_IDLE: begin
        cnt_next = '0;
        if (!ks_reg) begin
          state_next = ST_ARM;
          cnt_next   = CNT_ONE;
        end
      end
      ST_ARM: begin
        // The count equals the number of consecutive low samples already seen.
        if (ks_reg) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = ST_RESET;
          cnt_next   = '0;
          cause_next = CAUSE_KBD;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_RESET: begin
        cnt_next = '0;
        if (ks_reg) begin
          state_next = ST_HOLD;
          cnt_next   = CNT_ONE;
        end
      end
      ST_HOLD: begin
        // The first high sample counts as stretch cycle one.
        if (!ks_reg) begin
          state_next = ST_RESET;
          cnt_next   = '0;
        end else if (cnt_reg >= MIN_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_POR;
        cnt_next   = '0;
      end
    endcase
    assert_next = (state_next == ST_POR) || (state_next == ST_RESET) ||
                  (state_next == ST_HOLD);
  end

  // Registered assert flop keeps the open-drain requests glitch-free.
  assign _RST_O       = ~assert_reg;
  assign _HLT_O       = ~assert_reg;
  assign RESET_ACTIVE = assert_reg;
  assign CAUSE        = cause_reg;

endmodule

// File: tb/tb_amiga_reset_ctl.sv
// Bench for amiga_reset_ctl: run-length reference model feeding a per-cycle
// expectation queue, plus directed edge-count checks from the test plan.
module tb_amiga_reset_ctl;

  localparam int HOLD = 16;
  localparam int MIN  = 8;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       kclk = 1'b1;
  logic       rst_o, hlt_o, reset_active;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  logic [4:0] exp_q[$];

  // Reference model state: sync delay line and run-length counters
  logic       m_k1 = 1'b1, m_k2 = 1'b1;
  int         m_por_left = MIN;
  int         m_lowrun = 0;
  int         m_highs = 0;
  bit         m_kbd = 1'b0;
  logic [1:0] m_cause = 2'b01;

  amiga_reset_ctl #(
    .KCLK_HOLD_CYCLES(HOLD),
    .RESET_MIN_CYCLES(MIN),
    .CNT_W(23)
  ) dut (
    .CLK(clk),
    ._RES(res_n),
    .KCLK(kclk),
    ._RST_O(rst_o),
    ._HLT_O(hlt_o),
    .RESET_ACTIVE(reset_active),
    .CAUSE(cause)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic s;
    bit   asserted;
    if (!res_n) begin
      m_k1 = 1'b1;
      m_k2 = 1'b1;
      m_por_left = MIN;
      m_lowrun = 0;
      m_highs = 0;
      m_kbd = 1'b0;
      m_cause = 2'b01;
    end else begin
      s = m_k2;
      m_k2 = m_k1;
      m_k1 = kclk;
      if (m_por_left > 0) begin
        m_por_left--;
      end else if (m_kbd) begin
        if (s) m_highs++;
        else m_highs = 0;
        if (m_highs == MIN) begin
          m_kbd = 1'b0;
          m_lowrun = 0;
        end
      end else begin
        if (!s) m_lowrun++;
        else m_lowrun = 0;
        if (m_lowrun == HOLD) begin
          m_kbd = 1'b1;
          m_highs = 0;
          m_cause = 2'b10;
        end
      end
    end
    asserted = (!res_n) || (m_por_left > 0) || m_kbd;
    exp_q.push_back({~asserted, ~asserted, asserted, m_cause});
  endtask

  task automatic cyc(input logic k);
    kclk = k;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Drives k for n edges; first_change = edge index where RESET_ACTIVE first moved
  task automatic run(input logic k, input int n, output int first_change);
    logic start;
    start = reset_active;
    first_change = 0;
    for (int i = 1; i <= n; i++) begin
      cyc(k);
      if (first_change == 0 && reset_active !== start) first_change = i;
    end
    $display("run kclk=%b res_n=%b cycles=%0d first_change=%0d", k, res_n, n, first_change);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Scoreboard monitor: one expectation per clock edge, compared mid-cycle
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      cycle_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({rst_o, hlt_o, reset_active, cause} !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got rst/hlt/act/cause=%b expected %b",
                   cycle_no, {rst_o, hlt_o, reset_active, cause}, e);
        end
      end
    end
  end

  initial begin
    int fc;
    int lo_len, hi_len, rs_len;
    logic rk;

    // 1: power-on stretch
    res_n = 1'b0;
    run(1'b1, 3, fc);
    chk("por_active_in_reset", int'(reset_active), 1);
    res_n = 1'b1;
    run(1'b1, 12, fc);
    chk("por_release_edge", fc, MIN);
    chk("por_cause", int'(cause), 1);

    // 2: normal keyboard pulses never trigger
    for (int r = 0; r < 4; r++) begin
      run(1'b0, 10, fc);
      chk("short_low_no_reset", fc, 0);
      run(1'b1, 5, fc);
      chk("short_high_no_reset", fc, 0);
    end

    // 3: keyboard reset and release
    run(1'b0, 25, fc);
    chk("kbd_assert_edge", fc, 2 + HOLD);
    chk("kbd_cause", int'(cause), 2);
    chk("kbd_hlt_follows", int'(hlt_o), 0);
    run(1'b1, 15, fc);
    chk("kbd_release_edge", fc, 2 + MIN);

    // 4: re-low during the stretch restarts it
    run(1'b0, 20, fc);
    chk("relow_assert_edge", fc, 2 + HOLD);
    run(1'b1, 5, fc);
    chk("relow_stretch_held", fc, 0);
    run(1'b0, 3, fc);
    chk("relow_pulse_held", fc, 0);
    run(1'b1, 15, fc);
    chk("relow_release_edge", fc, 2 + MIN);

    // 5: threshold boundary, 15 vs 16 synced low samples
    run(1'b0, HOLD - 1, fc);
    chk("boundary15_low", fc, 0);
    run(1'b1, 20, fc);
    chk("boundary15_high", fc, 0);
    run(1'b0, HOLD, fc);
    chk("boundary16_low", fc, 0);
    run(1'b1, 2, fc);
    chk("boundary16_assert", fc, 2);
    run(1'b1, 14, fc);
    chk("boundary16_release", fc, MIN);

    // 6: asynchronous _RES during a keyboard reset
    run(1'b0, 20, fc);
    chk("async_kbd_assert", fc, 2 + HOLD);
    #6;
    res_n = 1'b0;
    #1;
    chk("async_cause_now", int'(cause), 1);
    chk("async_active_now", int'(reset_active), 1);
    run(1'b0, 2, fc);
    res_n = 1'b1;
    run(1'b0, 10, fc);
    chk("async_por_release", fc, MIN);
    run(1'b1, 5, fc);
    chk("async_after_idle", fc, 0);

    // Randomized KCLK low/high runs with occasional asynchronous power-on resets
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        #6;
        res_n = 1'b0;
        rk = 1'($urandom_range(0, 1));
        rs_len = int'($urandom_range(1, 3));
        run(rk, rs_len, fc);
        res_n = 1'b1;
      end
      lo_len = int'($urandom_range(1, 22));
      hi_len = int'($urandom_range(1, 14));
      run(1'b0, lo_len, fc);
      run(1'b1, hi_len, fc);
    end

    run(1'b1, 20, fc);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
